// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit.
// Size codes, fault causes and LSU state values.
package mem_pkg;

  typedef logic [1:0] size_t;
  typedef logic [1:0] cause_t;
  typedef logic [1:0] state_t;

  localparam size_t MEM_B = 2'b00;
  localparam size_t MEM_H = 2'b01;
  localparam size_t MEM_W = 2'b10;
  localparam size_t MEM_X = 2'b11;

  localparam cause_t CAUSE_NONE     = 2'b00;
  localparam cause_t CAUSE_MISALIGN = 2'b01;
  localparam cause_t CAUSE_TIMEOUT  = 2'b10;
  localparam cause_t CAUSE_ILLEGAL  = 2'b11;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_ACCESS = 2'b01;
  localparam state_t ST_RESP   = 2'b10;

endpackage

// File: rtl/mem_align_chk.sv
// Size legality and natural-alignment check.
// Purely combinational; evaluated on the incoming request.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       fault,
  output logic [1:0] cause
);

  always_comb begin
    fault = 1'b0;
    cause = CAUSE_NONE;
    unique case (1'b1)
      (size == MEM_X): begin
        fault = 1'b1;
        cause = CAUSE_ILLEGAL;
      end
      (size == MEM_H && addr_lo[0]): begin
        fault = 1'b1;
        cause = CAUSE_MISALIGN;
      end
      (size == MEM_W && addr_lo != 2'b00): begin
        fault = 1'b1;
        cause = CAUSE_MISALIGN;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the MEM stage and the DMem port.
// One request in flight; registered DMem drive and response.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [1:0]        resp_cause,
  output logic              dm_valid,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_read,
  output logic              dm_write,
  output logic [1:0]        dm_mask,
  output logic              dm_sext,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_good
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       chk_fault;
  logic [1:0] chk_cause;
  logic       to_hit;

  mem_align_chk u_chk (
    .size    (req_size),
    .addr_lo (req_addr[1:0]),
    .fault   (chk_fault),
    .cause   (chk_cause)
  );

  assign req_ready = (state == ST_IDLE);
  assign to_hit    = (cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dm_valid   <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      dm_read    <= 1'b0;
      dm_write   <= 1'b0;
      dm_mask    <= '0;
      dm_sext    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_cause <= CAUSE_NONE;
    end else if (flush) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dm_valid   <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      dm_read    <= 1'b0;
      dm_write   <= 1'b0;
      dm_mask    <= '0;
      dm_sext    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_cause <= CAUSE_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid && chk_fault) begin
            // faulting requests never touch DMem
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_fault <= 1'b1;
            resp_cause <= chk_cause;
          end else if (req_valid) begin
            state    <= ST_ACCESS;
            cnt      <= '0;
            dm_valid <= 1'b1;
            dm_addr  <= req_addr;
            dm_wdata <= req_wdata;
            dm_read  <= ~req_we;
            dm_write <= req_we;
            dm_mask  <= req_size;
            dm_sext  <= ~req_unsigned;
          end
        end
        ST_ACCESS: begin
          if (dm_good) begin
            state      <= ST_RESP;
            dm_valid   <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            dm_read    <= 1'b0;
            dm_write   <= 1'b0;
            dm_mask    <= '0;
            dm_sext    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= dm_read ? dm_rdata : '0;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
          end else if (to_hit) begin
            state      <= ST_RESP;
            dm_valid   <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            dm_read    <= 1'b0;
            dm_write   <= 1'b0;
            dm_mask    <= '0;
            dm_sext    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_fault <= 1'b1;
            resp_cause <= CAUSE_TIMEOUT;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_rw_excl: assert property (
    @(posedge clk) disable iff (!reset)
    !(dm_read && dm_write));

  a_resp_hold: assert property (
    @(posedge clk) disable iff (!reset)
    resp_valid && !resp_ready && !flush
    |=> resp_valid && $stable(resp_rdata)
        && $stable(resp_fault)
        && $stable(resp_cause));

  a_dm_hold: assert property (
    @(posedge clk) disable iff (!reset)
    state == ST_ACCESS && !dm_good
    && !to_hit && !flush
    |=> dm_valid && $stable(dm_addr)
        && $stable(dm_wdata)
        && $stable(dm_mask));

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a byte-array DMem model.
// Driver pushes expected responses; a negedge monitor checks.
module tb_mem_lsu;

  localparam int TO = 8;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic          flush;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [1:0]    resp_cause;
  logic          dm_valid;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_read;
  logic          dm_write;
  logic [1:0]    dm_mask;
  logic          dm_sext;
  logic [31:0]   dm_rdata;
  logic          dm_good;

  mem_lsu #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .resp_cause   (resp_cause),
    .dm_valid     (dm_valid),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_read      (dm_read),
    .dm_write     (dm_write),
    .dm_mask      (dm_mask),
    .dm_sext      (dm_sext),
    .dm_rdata     (dm_rdata),
    .dm_good      (dm_good)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic        uns;
    logic        fault;
    logic [1:0]  size;
    logic [1:0]  cause;
    int          lat;
    int          acc;
    int          dv;
    bit          to;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         acc = 0;
  int         rr_mode = 1;
  int         good_delay = 0;
  int         ref_mem[256];
  logic [7:0] dmem[256];
  logic [7:0] da;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // DMem model: combinational read, write on the good edge
  assign da = dm_addr[7:0];
  assign dm_good = dm_valid && (acc >= good_delay);

  always_comb begin
    case (dm_mask)
      2'b00: dm_rdata = {{24{dm_sext & dmem[da][7]}}, dmem[da]};
      2'b01: dm_rdata = {{16{dm_sext & dmem[da+8'd1][7]}},
                         dmem[da+8'd1], dmem[da]};
      default: dm_rdata = {dmem[da+8'd3], dmem[da+8'd2],
                           dmem[da+8'd1], dmem[da]};
    endcase
  end

  always @(posedge clk) begin
    acc <= dm_valid ? acc + 1 : 0;
    cyc <= cyc + 1;
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'((i * 37 + 11) & 255);
    forever begin
      @(posedge clk);
      if (dm_valid && dm_write && dm_good) begin
        dmem[da] = dm_wdata[7:0];
        if (dm_mask != 2'b00) dmem[da+8'd1] = dm_wdata[15:8];
        if (dm_mask == 2'b10) begin
          dmem[da+8'd2] = dm_wdata[23:16];
          dmem[da+8'd3] = dm_wdata[31:24];
        end
      end
    end
  end

  // reference: little-endian byte array, arithmetic extension
  function automatic logic [31:0] ref_load(int a, logic [1:0] size, logic uns);
    longint v;
    int nb;
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    v = 0;
    for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[a+i]);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  initial begin
    int held = 0;
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rr_mode == 0) resp_ready = ($urandom_range(0, 3) != 0);
      else if (rr_mode == 1) resp_ready = 1'b1;
      else begin
        if (resp_valid) held++;
        resp_ready = (held > 5);
      end
      if (rr_mode != 2) held = 0;
    end
  end

  task automatic wait_ready();
    bit got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_ready_wait: got 0, expected 1");
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic [1:0] size,
                       input logic uns, input int dly);
    exp_t e;
    int a;
    int nb;
    wait_ready();
    good_delay = dly;
    req_addr = addr;
    req_wdata = wd;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = int'(addr & 32'hFF);
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.addr = addr;
    e.wdata = wd;
    e.we = we;
    e.uns = uns;
    e.size = size;
    e.acc = cyc;
    e.to = 0;
    e.rdata = '0;
    e.fault = 1'b0;
    e.cause = 2'b00;
    if (size == 2'b11) begin
      e.fault = 1'b1;
      e.cause = 2'b11;
    end else if ((size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00)) begin
      e.fault = 1'b1;
      e.cause = 2'b01;
    end
    if (e.fault) begin
      e.lat = 1;
      e.dv = 0;
    end else if (dly >= TO) begin
      e.fault = 1'b1;
      e.cause = 2'b10;
      e.lat = TO + 1;
      e.dv = TO;
      e.to = 1;
    end else begin
      e.lat = dly + 2;
      e.dv = dly + 1;
      if (we) begin
        for (int i = 0; i < nb; i++)
          ref_mem[a+i] = int'((wd >> (8 * i)) & 32'hFF);
      end else begin
        e.rdata = ref_load(a, size, uns);
      end
    end
    q.push_back(e);
  endtask

  // monitor
  initial begin
    bit seen = 0;
    bit post_hs = 0;
    bit expect_idle = 0;
    int dv = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 0;
        post_hs = 0;
        dv = 0;
        expect_idle = 1;
      end else begin
        if (expect_idle) begin
          chk("idle_state", 128'({resp_valid, resp_rdata, resp_fault,
              resp_cause, dm_valid, dm_read, dm_write, dm_addr,
              dm_wdata, dm_mask, dm_sext, req_ready}), 128'd1);
          expect_idle = 0;
        end
        if (post_hs) begin
          chk("after_handshake", 128'({resp_valid, req_ready}), 128'd1);
          post_hs = 0;
        end
        chk("rw_exclusive", 128'(dm_read & dm_write), 128'd0);
        if (dm_valid) begin
          dv++;
          if (q.size() == 0) begin
            chk("dm_unexpected", 128'(dm_valid), 128'd0);
          end else begin
            chk("dm_fields", 128'({dm_addr, dm_wdata, dm_read, dm_write,
                dm_mask, dm_sext}), 128'({q[0].addr, q[0].wdata, !q[0].we,
                q[0].we, q[0].size, !q[0].uns}));
          end
        end
        if (resp_valid) begin
          if (!seen) begin
            if (q.size() == 0) begin
              chk("resp_unexpected", 128'(resp_valid), 128'd0);
            end else begin
              cur = q.pop_front();
              chk("resp", 128'({resp_rdata, resp_fault, resp_cause}),
                  128'({cur.rdata, cur.fault, cur.cause}));
              chk("latency", 128'(cyc - cur.acc + 1), 128'(cur.lat));
              chk("dm_cycles", 128'(dv), 128'(cur.dv));
              chk("dm_idle", 128'({dm_valid, dm_read, dm_write}), 128'd0);
              if (cur.to)
                chk("dm_cleared", 128'({dm_addr, dm_wdata, dm_mask, dm_sext}),
                    128'd0);
            end
            seen = 1;
            dv = 0;
          end else begin
            chk("resp_hold", 128'({resp_rdata, resp_fault, resp_cause,
                req_ready}), 128'({cur.rdata, cur.fault, cur.cause, 1'b0}));
          end
          if (resp_ready) begin
            post_hs = 1;
            seen = 0;
          end
        end
        if (flush) begin
          expect_idle = 1;
          seen = 0;
          dv = 0;
        end
      end
    end
  end

  always @(negedge reset) begin
    #1;
    chk("async_reset", 128'({dm_valid, dm_read, dm_write, resp_valid}), 128'd0);
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    int          pick;
    int          dly;
    reset = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = (i * 37 + 11) & 255;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    issue(32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 0);
    issue(32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 0);
    issue(32'h13, 32'h000000A5, 1'b1, 2'b00, 1'b0, 1);
    issue(32'h13, 32'h0, 1'b0, 2'b00, 1'b1, 0);
    issue(32'h13, 32'h0, 1'b0, 2'b00, 1'b0, 2);
    issue(32'h06, 32'h0, 1'b0, 2'b10, 1'b0, 0);
    issue(32'h01, 32'h1234, 1'b1, 2'b01, 1'b0, 0);
    issue(32'h08, 32'h0, 1'b0, 2'b11, 1'b0, 0);
    issue(32'h20, 32'h0, 1'b0, 2'b10, 1'b0, 50);
    issue(32'h24, 32'h55AA, 1'b1, 2'b10, 1'b0, TO);
    issue(32'h28, 32'h0, 1'b0, 2'b10, 1'b0, TO - 1);

    wait_ready();
    rr_mode = 2;
    issue(32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 rr_mode = 1;
    issue(32'h12, 32'h0, 1'b0, 2'b01, 1'b1, 0);

    issue(32'h40, 32'h0, 1'b0, 2'b10, 1'b0, 100);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    q.delete();

    req_addr = 32'h30;
    req_size = 2'b10;
    req_we = 1'b0;
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    flush = 1'b0;

    issue(32'h44, 32'h0, 1'b0, 2'b10, 1'b0, 100);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    issue(32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 0);

    rr_mode = 0;
    for (int n = 0; n < 200; n++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom();
      if (size != 2'b11 && $urandom_range(0, 3) != 0)
        addr = addr & ~((32'd1 << size) - 32'd1);
      pick = $urandom_range(0, 9);
      if (pick < 6) dly = pick % 4;
      else if (pick < 8) dly = TO - 1;
      else if (pick == 8) dly = TO;
      else dly = $urandom_range(TO, TO + 5);
      issue(addr, $urandom(), 1'($urandom_range(0, 1)), size,
            1'($urandom_range(0, 1)), dly);
    end

    rr_mode = 1;
    for (int n = 0; n < 100 && (q.size() != 0 || resp_valid); n++)
      @(posedge clk);
    @(negedge clk);
    chk("drain", 128'({32'(q.size()), resp_valid}), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit between the pipeline MEM stage and the DMem data port.
- Accepts one memory request at a time over a valid/ready handshake.
- Checks size and alignment, then drives the DMem port from registers and waits for `good`, with a bounded timeout.
- Captures load data or store completion and returns a registered response with a fault code, held until the pipeline accepts it.

Parameters:
TIMEOUT, 8, cycles `dm_good` may stay low in ACCESS before a bus-error fault (1..255).
ADDR_W, 32, request/DMem address width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request present
req_ready  out  1  LSU can accept (high only in IDLE)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, byte/half in low bits
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extend (LBU/LHU)
flush  in  1  abort current operation
resp_valid  out  1  response present
resp_ready  in  1  pipeline accepts response
resp_rdata  out  32  extended load data (0 for stores/faults)
resp_fault  out  1  access faulted
resp_cause  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal size
dm_valid  out  1  DMem valid
dm_addr  out  ADDR_W  DMem addr
dm_wdata  out  32  DMem writeData
dm_read  out  1  DMem memRead
dm_write  out  1  DMem memWrite
dm_mask  out  2  DMem maskMode (= req_size)
dm_sext  out  1  DMem sext (= ~req_unsigned)
dm_rdata  in  32  DMem readData
dm_good  in  1  DMem good

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - State is IDLE and the timeout counter is 0.
  - All dm_* outputs are 0.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0, resp_cause = 00.
  - req_ready = 1 once reset is released.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - Request accepted on an edge where req_valid and not flush.
- Size/alignment check at acceptance:
  - size 11 -> illegal.
  - Half with addr[0] = 1 -> misaligned.
  - Word with addr[1:0] != 00 -> misaligned.
- Faulting request:
  - DMem is never driven.
  - Go to RESP with resp_fault = 1 and the matching cause.
  - resp_valid is high the cycle after acceptance (latency 1).
- Legal request:
  - Register the dm_* outputs with dm_valid = 1, dm_read = ~we, dm_write = we.
  - Go to ACCESS. dm_* are stable throughout ACCESS.
  - dm_read and dm_write are never both 1.
- ACCESS:
  - When dm_good = 1 at a rising edge, clear dm_valid/read/write and go to RESP.
    - Load: resp_rdata <= dm_rdata.
    - Store: the DMem write occurs on that same edge; resp_rdata <= 0.
  - Latency: DMem answers combinationally, so resp_valid rises 2 cycles after acceptance.
  - Each cycle with dm_good = 0, the counter increments.
  - Counter == TIMEOUT-1 with good still low: deassert dm_*, go to RESP with fault cause 10.
- RESP:
  - resp_valid = 1; resp_rdata, resp_fault and resp_cause are held stable until resp_ready.
  - On resp_valid & resp_ready: clear resp_valid, return to IDLE.
  - No back-to-back overlap: a new request is accepted no earlier than the cycle after the response is consumed.
- flush (synchronous, highest priority):
  - From any state: go to IDLE next edge, with dm_* cleared, resp_valid = 0, counter = 0.
  - A store whose edge coincides with flush may complete in DMem; the LSU reports nothing.
- Simultaneous req_valid and flush in IDLE: the request is ignored.
- Reset mid-ACCESS: dm_* drop immediately (asynchronously); no response is produced.
- Counter is 8 bits, zeroed on entry to ACCESS, and saturates rather than wrapping.

Decomposition:
- Shared package `mem_pkg` holds:
  - Size encodings MEM_B/MEM_H/MEM_W.
  - Cause codes CAUSE_NONE/MISALIGN/TIMEOUT/ILLEGAL.
  - State encoding.
- One natural sub-module: `mem_align_chk`, combinational; inputs size and addr[1:0], outputs fault and cause.
- FSM, counter and port registers stay in mem_lsu.

Test Plan:
1. LW addr 0x10, DMem returns 0xDEADBEEF with good = 1 -> resp_valid 2 cycles after accept, rdata 0xDEADBEEF, fault 0; dm_read = 1 and dm_write = 0 during ACCESS.
2. SB addr 0x13, wdata 0x000000A5, then LBU and LB from 0x13 -> dm_mask 00; LBU rdata 0x000000A5 and LB rdata 0xFFFFFFA5 (checked with the DMem model).
3. LW addr 0x06 and SH addr 0x01 -> resp 1 cycle after accept, fault 1, cause 01, dm_valid never asserted; req_size 11 -> cause 11.
4. dm_good held 0, TIMEOUT = 8 -> dm_valid high exactly 8 cycles, then resp fault, cause 10, dm_* = 0.
5. resp_ready low for 5 cycles on a load -> resp_valid/rdata stable, req_ready = 0 throughout; accept next req the cycle after the handshake.
6. flush asserted in ACCESS, and reset pulsed low mid-ACCESS -> next cycle IDLE, resp_valid 0, dm_* 0 (reset: asynchronously); subsequent LW completes normally.
